// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth-table scanner.
// Holds the FSM state enum, row/mask/count widths.
package tt_pkg;

  localparam int NUM_INPUTS = 4;
  localparam int NUM_ROWS   = 16;
  localparam int MASK_W     = NUM_ROWS;
  localparam int CNT_W      = 5;

  typedef logic [NUM_INPUTS-1:0] row_t;
  typedef logic [MASK_W-1:0]     mask_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FINISH
  } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle counter: load restarts it, count advances it, expired marks
// the last hold cycle. Ports: clk, rst_n, load, count, expired.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam logic [3:0] LAST =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  logic [3:0] cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= '0;
    end else if (load) begin
      cyc <= '0;
    end else if (count && !expired) begin
      cyc <= cyc + 4'd1;
    end
  end

  assign expired = (cyc == LAST);

endmodule

// File: rtl/tt_scanner.sv
// Sweeps probe over all 16 rows of a 4-input function and records f_in.
// Ports: clk, rst_n, start, f_in, probe, busy, done, minterm_mask/cnt,
// is_const0/1; maxterm_mask/cnt with TT_SCANNER_MAXTERM_EN defined.
module tt_scanner
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic [3:0]  probe,
  output logic        busy,
  output logic        done,
  output logic [15:0] minterm_mask,
  output logic [4:0]  minterm_cnt,
`ifdef TT_SCANNER_MAXTERM_EN
  output logic [15:0] maxterm_mask,
  output logic [4:0]  maxterm_cnt,
`endif
  output logic        is_const0,
  output logic        is_const1
);

  localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);

  state_t state;
  logic   last_row;
  logic   t_load;
  logic   t_count;
  logic   t_expired;

  assign last_row = (probe == row_t'(NUM_ROWS - 1));

  // Timer restarts whenever a new row is about to be held in DRIVE.
  assign t_load  = ((state == IDLE) && start) ||
                   ((state == SAMPLE) && !last_row);
  assign t_count = (state == DRIVE);

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (t_load),
    .count  (t_count),
    .expired(t_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      probe        <= '0;
      minterm_mask <= '0;
      minterm_cnt  <= '0;
`ifdef TT_SCANNER_MAXTERM_EN
      maxterm_mask <= '1;
      maxterm_cnt  <= cnt_t'(NUM_ROWS);
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            probe        <= '0;
            minterm_mask <= '0;
            minterm_cnt  <= '0;
`ifdef TT_SCANNER_MAXTERM_EN
            maxterm_mask <= '1;
            maxterm_cnt  <= cnt_t'(NUM_ROWS);
`endif
            state <= NO_SETTLE ? SAMPLE : DRIVE;
          end
        end
        DRIVE: begin
          if (t_expired) state <= SAMPLE;
        end
        SAMPLE: begin
          minterm_mask[probe] <= f_in;
          minterm_cnt <= minterm_cnt + cnt_t'(f_in);
`ifdef TT_SCANNER_MAXTERM_EN
          maxterm_mask[probe] <= ~f_in;
          maxterm_cnt <= maxterm_cnt - cnt_t'(f_in);
`endif
          // Probe parks on row 15 through FINISH.
          if (last_row) begin
            state <= FINISH;
          end else begin
            probe <= probe + 4'd1;
            state <= NO_SETTLE ? SAMPLE : DRIVE;
          end
        end
        FINISH: begin
          probe <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == FINISH);

  assign is_const0 = (minterm_mask == 16'h0000);
  assign is_const1 = (minterm_mask == 16'hFFFF);

endmodule

// File: tb/tb_tt_scanner.sv
// Random and directed truth-table scans on two instances (settle 1 and 0).
module tb_tt_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  f_in;
  logic [3:0]  probe [2];
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [15:0] mmask [2];
  logic [4:0]  mcnt [2];
  logic [1:0]  c0;
  logic [1:0]  c1;
`ifdef TT_SCANNER_MAXTERM_EN
  logic [15:0] xmask [2];
  logic [4:0]  xcnt [2];
`endif

  logic [15:0] tt [2];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External function under test: a truth-table lookup on the probe.
  assign f_in[0] = tt[0][probe[0]];
  assign f_in[1] = tt[1][probe[1]];

  tt_scanner #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .f_in(f_in[0]),
    .probe(probe[0]), .busy(busy[0]), .done(done[0]),
    .minterm_mask(mmask[0]), .minterm_cnt(mcnt[0]),
`ifdef TT_SCANNER_MAXTERM_EN
    .maxterm_mask(xmask[0]), .maxterm_cnt(xcnt[0]),
`endif
    .is_const0(c0[0]), .is_const1(c1[0])
  );

  tt_scanner #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .f_in(f_in[1]),
    .probe(probe[1]), .busy(busy[1]), .done(done[1]),
    .minterm_mask(mmask[1]), .minterm_cnt(mcnt[1]),
`ifdef TT_SCANNER_MAXTERM_EN
    .maxterm_mask(xmask[1]), .maxterm_cnt(xcnt[1]),
`endif
    .is_const0(c0[1]), .is_const1(c1[1])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ones(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  // Model: mask equals the function's truth table; ranks from popcount.
  task automatic check_result(input int k, input logic [15:0] t);
    check("mask", 32'(mmask[k]), 32'(t));
    check("cnt", 32'(mcnt[k]), 32'(ones(t)));
    check("const0", 32'(c0[k]), 32'(t == 16'h0000));
    check("const1", 32'(c1[k]), 32'(t == 16'hFFFF));
`ifdef TT_SCANNER_MAXTERM_EN
    check("xmask", 32'(xmask[k]), 32'(~t));
    check("xcnt", 32'(xcnt[k]), 32'(16 - ones(t)));
`endif
  endtask

  // Runs one scan; kick_at>0 re-pulses start on that busy cycle.
  task automatic scan(input int k, input logic [15:0] t,
                      input int kick_at);
    int nb = 0;
    int exp_busy = (k == 0) ? 32 : 16;
    bit got = 1'b0;
    tt[k] = t;
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done[k]) begin
        got = 1'b1;
        break;
      end
      if (busy[k]) nb++;
      start[k] = (kick_at > 0) && (nb == kick_at) && busy[k];
      @(negedge clk);
    end
    start[k] = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("busy_cycles", 32'(nb), 32'(exp_busy));
    check("done_busy", 32'(busy[k]), 32'd0);
    check_result(k, t);
    @(negedge clk);
    check("done_pulse", 32'(done[k]), 32'd0);
    check("probe_idle", 32'(probe[k]), 32'd0);
    repeat (2) @(negedge clk);
    check("hold", 32'(mmask[k]), 32'(t));
  endtask

  function automatic logic [15:0] table_of(input int sel);
    logic [15:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      logic a, b, c, d;
      {a, b, c, d} = 4'(i);
      case (sel)
        0: r[i] = (~a & ~b & c & ~d) | (~a & b & c) |
                  (a & b & ~d) | (a & b & c & d);
        1: r[i] = ~(a ^ b);
        default: r[i] = d;
      endcase
    end
    return r;
  endfunction

  initial begin
    tt[0] = '0;
    tt[1] = '0;
    #3;
    check("rst_probe", 32'(probe[0]), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mask", 32'(mmask[0]), 32'd0);
    check("rst_cnt", 32'(mcnt[1]), 32'd0);
    check("rst_c0", 32'(c0), 32'd3);
    check("rst_c1", 32'(c1), 32'd0);
`ifdef TT_SCANNER_MAXTERM_EN
    check("rst_xmask", 32'(xmask[0]), 32'hFFFF);
    check("rst_xcnt", 32'(xcnt[0]), 32'd16);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    scan(0, table_of(0), 0);
    check("req_d0c4", 32'(mmask[0]), 32'hD0C4);
    check("req_cnt6", 32'(mcnt[0]), 32'd6);
    scan(0, table_of(1), 0);
    check("req_f00f", 32'(mmask[0]), 32'hF00F);
    scan(0, 16'h0000, 0);
    scan(0, 16'hFFFF, 0);
    scan(1, table_of(2), 0);
    check("req_aaaa", 32'(mmask[1]), 32'hAAAA);
    scan(0, 16'h1234, 10);
    scan(1, 16'h8421, 5);

    for (int n = 0; n < 8; n++) begin
      scan(n % 2, 16'($urandom), (n % 3 == 0) ? int'($urandom_range(1, 15)) : 0);
    end

    // Asynchronous abort at probe 5.
    tt[0] = 16'hFFFF;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int c = 0; c < 100 && probe[0] != 4'd5; c++) @(negedge clk);
    check("reach_p5", 32'(probe[0]), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_probe", 32'(probe[0]), 32'd0);
    check("abort_mask", 32'(mmask[0]), 32'd0);
    check("abort_cnt", 32'(mcnt[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    scan(0, 16'h5A3C, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_scanner.md
TT_SCANNER -- requirements
Module: tt_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles each probe vector is held before f_in is sampled (range 0..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, scan request, sampled only in IDLE.
REQ-005 The block SHALL have port f_in, input, 1, output of the external 4-input combinational function under test.
REQ-006 The block SHALL have port probe, output, 4, stimulus vector {a,b,c,d} with a as MSB, driven to the function under test.
REQ-007 The block SHALL have port busy, output, 1, high while a scan is in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking scan completion.
REQ-009 The block SHALL have port minterm_mask, output, 16, where bit i is the value of f_in sampled with probe==i.
REQ-010 The block SHALL have port minterm_cnt, output, 5, number of set bits in minterm_mask (0..16).
REQ-011 The block SHALL have ports is_const0 and is_const1, output, 1 each, high when minterm_mask is 16'h0000 or 16'hFFFF respectively.

Function
REQ-012 The FSM SHALL have states IDLE, DRIVE, SAMPLE, FINISH.
REQ-013 In IDLE, start==1 SHALL clear minterm_mask, minterm_cnt and probe to 0, then move to DRIVE, or to SAMPLE when SETTLE_CYCLES==0.
REQ-014 DRIVE SHALL hold probe for SETTLE_CYCLES cycles, then move to SAMPLE.
REQ-015 SAMPLE SHALL last one cycle: write f_in into minterm_mask[probe] and increment minterm_cnt when f_in==1.
REQ-016 From SAMPLE with probe<15, the block SHALL increment probe and return to DRIVE, or stay in SAMPLE when SETTLE_CYCLES==0.
REQ-017 From SAMPLE with probe==15, the block SHALL move to FINISH without wrapping probe in that cycle.
REQ-018 FINISH SHALL last one cycle with done==1 and busy==0, then return to IDLE with probe driven to 0.
REQ-019 Busy SHALL be high exactly in DRIVE and SAMPLE, giving 16*(SETTLE_CYCLES+1) busy cycles followed by the done cycle.
REQ-020 Start SHALL be ignored in DRIVE, SAMPLE and FINISH, with no restart, no queuing and no effect on latency.
REQ-021 Results SHALL hold stable from FINISH until the next accepted start.
REQ-022 is_const0 and is_const1 SHALL be combinational from minterm_mask, both low during a scan unless the partial mask already satisfies the condition, and qualified only by done.

Reset
REQ-023 While rst_n==0, the block SHALL be in state IDLE with probe=0, busy=0, done=0, minterm_mask=0 and minterm_cnt=0 (is_const0=1, is_const1=0).
REQ-024 Reset asserted mid-scan SHALL abort the scan immediately, asynchronously, and discard partial results.
REQ-025 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-026 With TT_SCANNER_MAXTERM_EN defined, the block SHALL add outputs maxterm_mask (16) = ~minterm_mask and maxterm_cnt (5) = 16 - minterm_cnt, both registered and reset to 16'hFFFF and 16.
REQ-027 Without TT_SCANNER_MAXTERM_EN, the maxterm ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package tt_pkg SHALL hold the FSM state enum, NUM_INPUTS=4, NUM_ROWS=16, and the mask and count widths.
REQ-029 The settle counter SHALL be sub-module tt_settle_timer, with inputs load and count and output expired, parameterised by SETTLE_CYCLES.

Verification
REQ-030 A test SHALL drive f=~a&~b&c&~d | ~a&b&c | a&b&~d | a&b&c&d with SETTLE_CYCLES=1 and start, and require busy for 32 cycles, then done, mask=16'hD0C4 and cnt=6.
REQ-031 A test SHALL drive f=a XNOR b and require mask=16'hF00F and cnt=8; with MAXTERM_EN it SHALL also require maxterm_mask=16'h0FF0 and maxterm_cnt=8.
REQ-032 A test SHALL tie f_in=0 and then f_in=1 and require mask 16'h0000, cnt 0, is_const0=1, then 16'hFFFF, cnt 16, is_const1=1.
REQ-033 A test SHALL set SETTLE_CYCLES=0 with f=d and require busy for 16 cycles and mask=16'hAAAA.
REQ-034 A test SHALL pulse start at the 10th busy cycle and require it ignored, with done at the same cycle as an unperturbed scan.
REQ-035 A test SHALL pulse rst_n low while probe==5 and require busy, probe and mask to drop to 0 asynchronously, and a new start to then run a full scan.
